timer_chain_ctrl: RTL

- Programmable interval timer controller that sequences a chain of NUM_STAGES cascaded 4-bit presettable synchronous counters.
- Drives the chain's load, count-enable (enp/ent) and ripple-carry cascade.
- Supports one-shot and periodic modes.
- Raises a terminal-count pulse and a sticky interrupt flag.
- Used for sound, IRQ and frame-timing dividers alongside the video counters.

---
 rtl/timer_chain_pkg.sv | 14 +
 rtl/timer_chain_ctrl_ls161.sv | 31 +++
 rtl/timer_chain_ctrl.sv | 193 +++++++++++++++++++
 3 files changed

// File: rtl/timer_chain_pkg.sv
// timer_chain_pkg: shared types and constants for the interval timer chain.
// Holds the controller state encoding and the width of one counter stage.
package timer_chain_pkg;

    localparam int STAGE_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2,
        DONE = 2'd3
    } state_t;

endpackage

// File: rtl/timer_chain_ctrl_ls161.sv
// timer_chain_ctrl_ls161: model of the 4-bit presettable synchronous counter
// used as one stage of the timer chain. Asynchronous clear, synchronous
// load, counts when both enp and ent are high. rco is ent gated with the
// all-ones state so stages cascade without waiting for tick.
module timer_chain_ctrl_ls161
    import timer_chain_pkg::*;
(
    input  logic               clk,
    input  logic               n_clr,
    input  logic               n_load,
    input  logic               enp,
    input  logic               ent,
    input  logic [STAGE_W-1:0] d,
    output logic [STAGE_W-1:0] q,
    output logic               rco
);

    // Counter register: load has priority over counting, clear over both
    always_ff @(posedge clk or negedge n_clr) begin
        if (!n_clr) begin
            q <= '0;
        end else if (!n_load) begin
            q <= d;
        end else if (enp && ent) begin
            q <= q + 1'b1;
        end
    end

    assign rco = ent & (&q);

endmodule

// File: rtl/timer_chain_ctrl.sv
// timer_chain_ctrl: programmable interval timer sequencing a cascade of
// NUM_STAGES 4-bit counters. The chain counts up from a shadowed preset to
// all-ones on each tick while running; the terminal event either reloads the
// preset (periodic) or parks the chain at all-ones (one-shot). A registered
// tc_pulse and a sticky irq flag report terminal events.
// Optional build macro TIMER_CHAIN_CAPTURE_EN adds a count snapshot register
// (cap_strobe in, cap_q out).
module timer_chain_ctrl
    import timer_chain_pkg::*;
#(
    parameter int NUM_STAGES = 3,
    localparam int W = STAGE_W * NUM_STAGES
)
(
    input  logic         clk,
    input  logic         n_clr,
    input  logic         tick,
    input  logic         cfg_wr,
    input  logic [W-1:0] cfg_preset,
    input  logic         cfg_periodic,
    input  logic         start,
    input  logic         stop,
    input  logic         irq_ack,
`ifdef TIMER_CHAIN_CAPTURE_EN
    input  logic         cap_strobe,
    output logic [W-1:0] cap_q,
`endif
    output logic [W-1:0] count,
    output logic         busy,
    output logic         tc_pulse,
    output logic         irq
);

    state_t          state;
    state_t          state_nxt;

    logic [W-1:0]    preset_q;
    logic            periodic_q;
    logic [W-1:0]    eff_preset;
    logic            eff_periodic;

    logic            run_en;
    logic            load_now;
    logic            term;
    logic            term_evt;
    logic            n_load;
    logic [W-1:0]    load_val;

    logic [NUM_STAGES-1:0] ent;
    logic [NUM_STAGES-1:0] rco;

    logic            tc_q;
    logic            irq_q;

    // A config write in the same cycle as a reload takes effect immediately,
    // so the reload path looks through the shadow registers to the inputs.
    assign eff_preset   = cfg_wr ? cfg_preset   : preset_q;
    assign eff_periodic = cfg_wr ? cfg_periodic : periodic_q;

    // The last stage's carry is the all-ones detect of the whole chain.
    assign term     = rco[NUM_STAGES-1];
    assign term_evt = tick & term;

    // Load on the LOAD cycle and on any terminal event. A one-shot terminal
    // reloads all-ones, which holds the chain instead of wrapping to zero.
    assign n_load   = ~(load_now | term_evt);
    assign load_val = (term_evt && !eff_periodic) ? {W{1'b1}} : eff_preset;

    // State register
    always_ff @(posedge clk or negedge n_clr) begin
        if (!n_clr) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic: stop beats start, start in RUN restarts via LOAD
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE, DONE: begin
                if (start && !stop) begin
                    state_nxt = LOAD;
                end
            end
            LOAD: begin
                if (stop) begin
                    state_nxt = IDLE;
                end else begin
                    state_nxt = RUN;
                end
            end
            RUN: begin
                if (stop) begin
                    state_nxt = IDLE;
                end else if (start) begin
                    state_nxt = LOAD;
                end else if (term_evt && !eff_periodic) begin
                    state_nxt = DONE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Output decode: run enable is withheld on stop/start so the chain holds
    // and no terminal event can fire in a cycle that leaves RUN.
    always_comb begin
        busy     = 1'b0;
        run_en   = 1'b0;
        load_now = 1'b0;
        case (state)
            LOAD: begin
                busy     = 1'b1;
                load_now = !stop;
            end
            RUN: begin
                busy   = 1'b1;
                run_en = !stop && !start;
            end
            default: begin
                busy     = 1'b0;
                run_en   = 1'b0;
                load_now = 1'b0;
            end
        endcase
    end

    // Shadow configuration registers
    always_ff @(posedge clk or negedge n_clr) begin
        if (!n_clr) begin
            preset_q   <= '0;
            periodic_q <= 1'b0;
        end else if (cfg_wr) begin
            preset_q   <= cfg_preset;
            periodic_q <= cfg_periodic;
        end
    end

    // Terminal-count pulse and sticky interrupt; a terminal event beats ack
    always_ff @(posedge clk or negedge n_clr) begin
        if (!n_clr) begin
            tc_q  <= 1'b0;
            irq_q <= 1'b0;
        end else begin
            tc_q <= term_evt;
            if (term_evt) begin
                irq_q <= 1'b1;
            end else if (irq_ack) begin
                irq_q <= 1'b0;
            end
        end
    end

    assign tc_pulse = tc_q;
    assign irq      = irq_q;

    // Carry cascade: stage 0 is enabled by run_en, each later stage by the
    // carry of the one below; every stage sees tick on enp.
    assign ent[0] = run_en;

    genvar k;
    generate
        for (k = 0; k < NUM_STAGES; k++) begin : g_stage
            if (k > 0) begin : g_cascade
                assign ent[k] = rco[k-1];
            end
            timer_chain_ctrl_ls161 u_ls161 (
                .clk    (clk),
                .n_clr  (n_clr),
                .n_load (n_load),
                .enp    (tick),
                .ent    (ent[k]),
                .d      (load_val[k*STAGE_W +: STAGE_W]),
                .q      (count[k*STAGE_W +: STAGE_W]),
                .rco    (rco[k])
            );
        end
    endgenerate

`ifdef TIMER_CHAIN_CAPTURE_EN
    // Count snapshot; non-blocking sampling captures the pre-increment value
    always_ff @(posedge clk or negedge n_clr) begin
        if (!n_clr) begin
            cap_q <= '0;
        end else if (cap_strobe) begin
            cap_q <= count;
        end
    end
`endif

endmodule
